// File: rtl/hyperram_tx_seq.sv
// HyperBus transmit sequencer: serialises the 48-bit CA word, counts the
// initial latency, streams masked write bytes and releases the bus for reads.
// One byte per clk_i cycle; hr_ck_o toggles every cycle while CS# is low.
module hyperram_tx_seq #(
    parameter int LATENCY    = 6,
    parameter int RECOVERY   = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_read_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [7:0]  cmd_len_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  wmask_i,
    input  logic        rd_done_i,
    output logic        rd_active_o,
    output logic        err_o,
    output logic        hr_csn_o,
    output logic        hr_ck_o,
    output logic [7:0]  hr_dq_o,
    output logic        hr_dq_oe_o,
    output logic        hr_rwds_o,
    output logic        hr_rwds_oe_o,
    input  logic        hr_rwds_i
);

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WRITE, S_READ, S_END} state_t;

    localparam int             RDW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [7:0]     LAT_1X   = 8'(2 * LATENCY - 1);
    localparam logic [7:0]     LAT_2X   = 8'(4 * LATENCY - 1);
    localparam logic [7:0]     REC_LAST = 8'(RECOVERY - 1);
    localparam logic [RDW-1:0] RD_LAST  = RDW'(RD_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [8:0]      words_q, words_d;     // words still to issue after the current one
    logic            read_q, read_d;
    logic            dbl_q, dbl_d;
    logic            exit_q, exit_d;       // read finished on an even cycle: one pad cycle
    logic [47:0]     ca_q, ca_d;
    logic [15:0]     wword_q, wword_d;
    logic [1:0]      wmask_q, wmask_d;
    logic [RDW-1:0]  rd_cnt_q, rd_cnt_d;
    logic            take_word;

    logic            cmd_ready_q, cmd_ready_d;
    logic            csn_q, csn_d;
    logic            ck_q, ck_d;
    logic [7:0]      dq_q, dq_d;
    logic            dq_oe_q, dq_oe_d;
    logic            rwds_q, rwds_d;
    logic            rwds_oe_q, rwds_oe_d;
    logic            wready_q, wready_d;
    logic            rd_active_q, rd_active_d;
    logic            err_q, err_d;
    logic            active;

    // Next-state and datapath: transitions, counters, CA shifter, write capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        words_d   = words_q;
        read_d    = read_q;
        dbl_d     = dbl_q;
        exit_d    = exit_q;
        ca_d      = ca_q;
        wword_d   = wword_q;
        wmask_d   = wmask_q;
        rd_cnt_d  = rd_cnt_q;
        wready_d  = 1'b0;
        err_d     = 1'b0;
        take_word = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d = S_CA;
                    cnt_d   = 8'd0;
                    read_d  = cmd_read_i;
                    dbl_d   = 1'b0;
                    words_d = (cmd_len_i == 8'd0) ? 9'd1 : {1'b0, cmd_len_i};
                    ca_d    = {cmd_read_i, 1'b0, 1'b1, cmd_addr_i[31:3], 13'd0, cmd_addr_i[2:0]};
                end
            end
            S_CA: begin
                ca_d = {ca_q[39:0], 8'h00};
                if (cnt_q == 8'd2) dbl_d = hr_rwds_i;
                if (cnt_q == 8'd5) begin
                    state_d = S_LAT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LAT: begin
                if (cnt_q == (dbl_q ? LAT_2X : LAT_1X)) begin
                    if (read_q) begin
                        state_d  = S_READ;
                        rd_cnt_d = '0;
                        exit_d   = 1'b0;
                    end else begin
                        take_word = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                // ck_q high marks the odd (low-byte) cycle; the next word starts after it
                if (ck_q) begin
                    if (words_q == 9'd0) begin
                        state_d = S_END;
                        cnt_d   = 8'd0;
                    end else begin
                        take_word = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (exit_q) begin
                    state_d = S_END;
                    cnt_d   = 8'd0;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_done_i || rd_cnt_q == RD_LAST) begin
                        err_d = ~rd_done_i;
                        if (ck_q) begin
                            state_d = S_END;
                            cnt_d   = 8'd0;
                        end else begin
                            exit_d = 1'b1;
                        end
                    end
                end
            end
            S_END: begin
                if (cnt_q == REC_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
        // Start of a word: consume it, or abort cleanly on underrun
        if (take_word) begin
            if (wdata_valid_i) begin
                state_d  = S_WRITE;
                wword_d  = wdata_i;
                wmask_d  = wmask_i;
                words_d  = words_q - 9'd1;
                wready_d = 1'b1;
            end else begin
                state_d = S_END;
                cnt_d   = 8'd0;
                err_d   = 1'b1;
            end
        end
    end

    // Output decode from the next state so every pin comes straight from a flop
    always_comb begin
        active      = (state_d == S_CA) || (state_d == S_LAT) ||
                      (state_d == S_WRITE) || (state_d == S_READ);
        csn_d       = ~active;
        ck_d        = (active && state_q != S_IDLE) ? ~ck_q : 1'b0;
        cmd_ready_d = (state_d == S_IDLE);
        rd_active_d = (state_d == S_READ);
        dq_d        = 8'h00;
        dq_oe_d     = 1'b0;
        rwds_d      = 1'b0;
        rwds_oe_d   = 1'b0;
        case (state_d)
            S_CA: begin
                dq_oe_d = 1'b1;
                dq_d    = ca_d[47:40];
            end
            S_LAT: begin
                if (!read_d && cnt_d == (dbl_d ? LAT_2X : LAT_1X)) begin
                    dq_oe_d   = 1'b1;
                    rwds_oe_d = 1'b1;
                end
            end
            S_WRITE: begin
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                dq_d      = ck_d ? wword_d[7:0] : wword_d[15:8];
                rwds_d    = ck_d ? wmask_d[0]   : wmask_d[1];
            end
            default: ;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            words_q     <= 9'd0;
            read_q      <= 1'b0;
            dbl_q       <= 1'b0;
            exit_q      <= 1'b0;
            ca_q        <= 48'd0;
            wword_q     <= 16'd0;
            wmask_q     <= 2'd0;
            rd_cnt_q    <= '0;
            cmd_ready_q <= 1'b0;
            csn_q       <= 1'b1;
            ck_q        <= 1'b0;
            dq_q        <= 8'h00;
            dq_oe_q     <= 1'b0;
            rwds_q      <= 1'b0;
            rwds_oe_q   <= 1'b0;
            wready_q    <= 1'b0;
            rd_active_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            read_q      <= read_d;
            dbl_q       <= dbl_d;
            exit_q      <= exit_d;
            ca_q        <= ca_d;
            wword_q     <= wword_d;
            wmask_q     <= wmask_d;
            rd_cnt_q    <= rd_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            csn_q       <= csn_d;
            ck_q        <= ck_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            rwds_q      <= rwds_d;
            rwds_oe_q   <= rwds_oe_d;
            wready_q    <= wready_d;
            rd_active_q <= rd_active_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign hr_csn_o      = csn_q;
    assign hr_ck_o       = ck_q;
    assign hr_dq_o       = dq_q;
    assign hr_dq_oe_o    = dq_oe_q;
    assign hr_rwds_o     = rwds_q;
    assign hr_rwds_oe_o  = rwds_oe_q;
    assign wdata_ready_o = wready_q;
    assign rd_active_o   = rd_active_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_hyperram_tx_seq.sv
// Testbench for hyperram_tx_seq: directed and random transactions compared
// cycle by cycle against a timeline computed from the bus rules.
module tb_hyperram_tx_seq;

    localparam int LATENCY  = 6;
    localparam int RECOVERY = 4;
    localparam int RD_TO    = 255;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_read_i = 1'b0;
    logic [31:0] cmd_addr_i = 32'd0;
    logic [7:0]  cmd_len_i = 8'd0;
    logic        wdata_valid_i = 1'b0;
    logic        wdata_ready_o;
    logic [15:0] wdata_i = 16'd0;
    logic [1:0]  wmask_i = 2'd0;
    logic        rd_done_i = 1'b0;
    logic        rd_active_o;
    logic        err_o;
    logic        hr_csn_o;
    logic        hr_ck_o;
    logic [7:0]  hr_dq_o;
    logic        hr_dq_oe_o;
    logic        hr_rwds_o;
    logic        hr_rwds_oe_o;
    logic        hr_rwds_i = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] wq [8];
    logic [1:0]  mq [8];

    hyperram_tx_seq #(.LATENCY(LATENCY), .RECOVERY(RECOVERY), .RD_TIMEOUT(RD_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_read_i(cmd_read_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wmask_i(wmask_i),
        .rd_done_i(rd_done_i), .rd_active_o(rd_active_o), .err_o(err_o),
        .hr_csn_o(hr_csn_o), .hr_ck_o(hr_ck_o), .hr_dq_o(hr_dq_o), .hr_dq_oe_o(hr_dq_oe_o),
        .hr_rwds_o(hr_rwds_o), .hr_rwds_oe_o(hr_rwds_oe_o), .hr_rwds_i(hr_rwds_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
            $error("%s got %h want %h", tag, obs, exp);
        end
    endtask

    // {csn, ck, dq_oe, rwds_oe, wready, rd_active, err, cmd_ready}
    function automatic logic [15:0] ctl_obs();
        return {8'h00, hr_csn_o, hr_ck_o, hr_dq_oe_o, hr_rwds_oe_o,
                wdata_ready_o, rd_active_o, err_o, cmd_ready_o};
    endfunction

    // One transaction from handshake to the first IDLE cycle after recovery.
    // n_avail: write words the source offers; done_idx: READ cycle index of rd_done (-1 none);
    // abort_at: cycle at which reset is applied instead (-1 none).
    task automatic run_txn(input string name, input bit rd, input logic [31:0] addr,
                           input logic [7:0] len, input bit dbl, input int n_avail,
                           input int done_idx, input int abort_at);
        int len_eff, lat, w0, n, body, t, tlow, total, err_c, w, k;
        bit exp_err, ok;
        bit e_csn, e_ck, e_doe, e_roe, e_wr, e_ra, e_err, e_rdy;
        logic [47:0] ca;
        logic [7:0]  e_dq;
        logic        e_rwds;

        len_eff = (len == 8'd0) ? 1 : int'(len);
        lat     = dbl ? 4 * LATENCY : 2 * LATENCY;
        w0      = 6 + lat;
        ca      = {rd, 1'b0, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        n       = 0;
        if (!rd) begin
            n       = (n_avail < len_eff) ? n_avail : len_eff;
            body    = 2 * n;
            exp_err = (n_avail < len_eff);
            err_c   = w0 + body;
        end else begin
            if (done_idx >= 0 && done_idx <= RD_TO - 1) begin
                t = done_idx; exp_err = 1'b0;
            end else begin
                t = RD_TO - 1; exp_err = 1'b1;
            end
            body  = (t % 2 == 1) ? t + 1 : t + 2;
            err_c = w0 + t + 1;
        end
        tlow  = w0 + body;
        total = tlow + RECOVERY + 1;

        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            ok = cmd_ready_o;
        end
        chk({name, " ready_before"}, 16'(cmd_ready_o), 16'd1);

        cmd_valid_i   = 1'b1;
        cmd_read_i    = rd;
        cmd_addr_i    = addr;
        cmd_len_i     = len;
        w             = 0;
        wdata_i       = wq[0];
        wmask_i       = mq[0];
        wdata_valid_i = (n_avail > 0);
        hr_rwds_i     = 1'($urandom);
        rd_done_i     = 1'b0;

        for (int c = 0; c < total; c++) begin
            @(negedge clk_i);
            if (c == abort_at) begin
                rst_i = 1'b1;
                @(negedge clk_i);
                rst_i         = 1'b0;
                cmd_valid_i   = 1'b0;
                wdata_valid_i = 1'b0;
                rd_done_i     = 1'b0;
                chk({name, " abort_ctl"}, ctl_obs(), 16'h0080);
                chk({name, " abort_dq"}, 16'(hr_dq_o), 16'h0000);
                chk({name, " abort_rwds"}, 16'(hr_rwds_o), 16'h0000);
                $display("txn %s: reset applied at cycle %0d", name, c);
                return;
            end
            e_csn = !(c < tlow);
            e_ck  = (c < tlow) ? (c % 2 == 1) : 1'b0;
            e_doe = (c < 6) || (!rd && c >= w0 - 1 && c < w0 + 2 * n);
            e_roe = !rd && c >= w0 - 1 && c < tlow;
            e_wr  = !rd && c >= w0 && c < tlow && ((c - w0) % 2 == 0);
            e_ra  = rd && c >= w0 && c < tlow;
            e_err = exp_err && (c == err_c);
            e_rdy = (c == total - 1);
            chk($sformatf("%s ctl c%0d", name, c), ctl_obs(),
                {8'h00, e_csn, e_ck, e_doe, e_roe, e_wr, e_ra, e_err, e_rdy});
            if (e_doe) begin
                if (c < 6)            e_dq = ca[8 * (5 - c) +: 8];
                else if (c == w0 - 1) e_dq = 8'h00;
                else begin
                    k    = (c - w0) / 2;
                    e_dq = ((c - w0) % 2 == 0) ? wq[k][15:8] : wq[k][7:0];
                end
                chk($sformatf("%s dq c%0d", name, c), 16'(hr_dq_o), 16'(e_dq));
            end
            if (e_roe) begin
                if (c == w0 - 1) e_rwds = 1'b0;
                else begin
                    k      = (c - w0) / 2;
                    e_rwds = ((c - w0) % 2 == 0) ? mq[k][1] : mq[k][0];
                end
                chk($sformatf("%s rwds c%0d", name, c), 16'(hr_rwds_o), 16'(e_rwds));
            end
            // Inputs for the edge that ends cycle c
            cmd_valid_i = (c < total - 1) ? 1'($urandom) : 1'b0;
            cmd_read_i  = 1'($urandom);
            cmd_addr_i  = $urandom;
            hr_rwds_i   = (c == 2) ? dbl : 1'($urandom);
            if (wdata_ready_o) begin
                w++;
                if (w < 8) begin
                    wdata_i = wq[w];
                    wmask_i = mq[w];
                end
                wdata_valid_i = (w < n_avail);
            end
            rd_done_i = (rd && done_idx >= 0 && c == w0 + done_idx) || (c == 3);
        end
        cmd_valid_i   = 1'b0;
        wdata_valid_i = 1'b0;
        rd_done_i     = 1'b0;
        $display("txn %s: rd=%0d addr=%h len=%0d dbl=%0d cs_low=%0d err_expected=%0d",
                 name, rd, addr, len, dbl, tlow, exp_err);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            wq[i] = 16'($urandom);
            mq[i] = 2'($urandom);
        end
    endtask

    initial begin
        int len_r, avail_r, done_r;
        bit rd_r;

        fill_random();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("reset ctl", ctl_obs(), 16'h0080);
        chk("reset dq", 16'(hr_dq_o), 16'h0000);
        chk("reset rwds", 16'(hr_rwds_o), 16'h0000);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready after reset", 16'(cmd_ready_o), 16'd1);

        // Plain write, two words, no masking
        wq[0] = 16'hA55A; wq[1] = 16'h1234; mq[0] = 2'b00; mq[1] = 2'b00;
        run_txn("t1_write", 1'b0, 32'h0000_1234, 8'd2, 1'b0, 2, -1, -1);

        // Read with doubled latency, done after 16 READ cycles
        run_txn("t2_read", 1'b1, 32'h0000_0010, 8'd4, 1'b1, 0, 15, -1);

        // Write underrun before the third word
        fill_random();
        run_txn("t3_underrun", 1'b0, $urandom, 8'd3, 1'b0, 2, -1, -1);

        // Read that never completes: timeout
        run_txn("t4_timeout", 1'b1, $urandom, 8'd2, 1'($urandom), 0, -1, -1);

        // Reset in the middle of a write, then a clean command
        fill_random();
        run_txn("t5_abort", 1'b0, $urandom, 8'd4, 1'b0, 4, -1, 6 + 2 * LATENCY + 3);

        // Length 0 means one word; high byte masked
        wq[0] = 16'hC3E1; mq[0] = 2'b10;
        run_txn("t6_len0", 1'b0, 32'h8000_0007, 8'd0, 1'b0, 1, -1, -1);

        // rd_done coinciding with the timeout is a success; done on an even index pads a cycle
        run_txn("t7_done_at_timeout", 1'b1, $urandom, 8'd1, 1'b0, 0, RD_TO - 1, -1);
        run_txn("t8_done_even", 1'b1, $urandom, 8'd1, 1'b1, 0, 4, -1);

        // Random mix
        for (int r = 0; r < 12; r++) begin
            fill_random();
            rd_r    = 1'($urandom);
            len_r   = $urandom_range(0, 8);
            avail_r = (len_r == 0) ? 1 : len_r;
            if ($urandom_range(0, 3) == 0) avail_r = $urandom_range(0, avail_r);
            done_r  = $urandom_range(0, 40);
            run_txn($sformatf("rnd%0d", r), rd_r, $urandom, 8'(len_r), 1'($urandom),
                    avail_r, done_r, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
